// File: rtl/inst_mem_sync.sv
// ---------------------------------------------------------------------------
// inst_mem_sync
//  Byte-programmable instruction memory with a synchronous word fetch port.
//  A small FSM (IDLE/PROG/FULL) makes programming and fetch mutually
//  exclusive. The program port writes one byte per accepted handshake at an
//  auto-incrementing pointer. The fetch port returns one little-endian word
//  one cycle after each request.
//
//  Ports
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_prog_en            program mode request
//   i_prog_addr          start pointer, loaded on entry to programming
//   i_prog_valid/_data   byte stream; accepted when valid && o_prog_ready
//   o_prog_ready         registered, high only while in PROG
//   o_prog_err           sticky: a byte was dropped because the array is full
//   o_prog_csum          XOR of accepted bytes since programming entry
//   i_fetch_req/_addr    fetch request and byte address of the word's LSB
//   o_fetch_valid        one-cycle response strobe
//   o_fetch_data         {mem[a+3], ..., mem[a]}, held while not valid
//   o_fetch_err          response invalid (out of range or busy programming)
//
//  Configuration macro: INST_MEM_CHECKSUM_EN
//   defined   : o_prog_csum is a running XOR checksum register
//   undefined : o_prog_csum is tied to zero and no register is built
// ---------------------------------------------------------------------------
module inst_mem_sync #(
    parameter int ADDR_BITS  = 8,
    parameter int DEPTH      = 128,
    parameter int WORD_BYTES = 4,
    parameter int BYTE_W     = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_prog_en,
    input  logic [ADDR_BITS-1:0]         i_prog_addr,
    input  logic                         i_prog_valid,
    input  logic [BYTE_W-1:0]            i_prog_data,
    output logic                         o_prog_ready,
    output logic                         o_prog_err,
    output logic [BYTE_W-1:0]            o_prog_csum,
    input  logic                         i_fetch_req,
    input  logic [ADDR_BITS-1:0]         i_fetch_addr,
    output logic                         o_fetch_valid,
    output logic [WORD_BYTES*BYTE_W-1:0] o_fetch_data,
    output logic                         o_fetch_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so pointer and fetch arithmetic never wrap.
    localparam int AW = ADDR_BITS + 1;
    localparam int DW = WORD_BYTES * BYTE_W;
    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);
    localparam logic [AW-1:0] LAST_W  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] SPAN_W  = AW'(WORD_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROG = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic              ready_q, ready_d;
    logic              perr_q, perr_d;
    logic              fvalid_q, fvalid_d;
    logic              ferr_q, ferr_d;
    logic [DW-1:0]     fdata_q, fdata_d;
    logic              wr_en_s;
    logic [AW-1:0]     fidx_s;
    logic [BYTE_W-1:0] mem_q [DEPTH];

    // Program FSM next state, pointer, ready and sticky error.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        perr_d  = perr_q;
        wr_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_prog_en) begin
                    ptr_d  = {1'b0, i_prog_addr};
                    perr_d = 1'b0;
                    // A start pointer past the array goes straight to FULL so
                    // ready never rises for an unwritable address.
                    if ({1'b0, i_prog_addr} >= DEPTH_W) begin
                        state_d = ST_FULL;
                    end else begin
                        state_d = ST_PROG;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROG: begin
                if (i_prog_valid && ready_q) begin
                    wr_en_s = 1'b1;
                    ptr_d   = ptr_q + AW'(1);
                end else begin
                    ptr_d   = ptr_q;
                end
                if (!i_prog_en) begin
                    state_d = ST_IDLE;
                end else if (wr_en_s && (ptr_q == LAST_W)) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_PROG;
                end
            end
            ST_FULL: begin
                if (i_prog_valid) begin
                    perr_d = 1'b1;
                end else begin
                    perr_d = perr_q;
                end
                if (!i_prog_en) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_PROG);
    end

    // Fetch response: busy responses carry error and zero data; otherwise
    // out-of-range bytes read zero and a straddling word is flagged.
    always_comb begin
        fvalid_d = i_fetch_req;
        ferr_d   = ferr_q;
        fdata_d  = fdata_q;
        fidx_s   = {AW{1'b0}};
        if (i_fetch_req) begin
            if (state_q != ST_IDLE) begin
                ferr_d  = 1'b1;
                fdata_d = {DW{1'b0}};
            end else begin
                ferr_d = (({1'b0, i_fetch_addr} + SPAN_W) >= DEPTH_W);
                for (int k = 0; k < WORD_BYTES; k++) begin
                    fidx_s = {1'b0, i_fetch_addr} + AW'(k);
                    if (fidx_s < DEPTH_W) begin
                        fdata_d[k*BYTE_W +: BYTE_W] = mem_q[fidx_s[IDX_W-1:0]];
                    end else begin
                        fdata_d[k*BYTE_W +: BYTE_W] = {BYTE_W{1'b0}};
                    end
                end
            end
        end else begin
            ferr_d  = ferr_q;
            fdata_d = fdata_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= {AW{1'b0}};
            ready_q  <= 1'b0;
            perr_q   <= 1'b0;
            fvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            fdata_q  <= {DW{1'b0}};
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            ready_q  <= ready_d;
            perr_q   <= perr_d;
            fvalid_q <= fvalid_d;
            ferr_q   <= ferr_d;
            fdata_q  <= fdata_d;
        end
    end

    // Byte array: cleared on reset, written at the pointer on each accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {BYTE_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_q[ptr_q[IDX_W-1:0]] <= i_prog_data;
        end
    end

`ifdef INST_MEM_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic              csum_clr_s;

    // Checksum restarts on programming entry and folds in each accepted byte.
    always_comb begin
        csum_clr_s = (state_q == ST_IDLE) && i_prog_en;
        if (csum_clr_s) begin
            csum_d = {BYTE_W{1'b0}};
        end else if (wr_en_s) begin
            csum_d = csum_q ^ i_prog_data;
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            csum_q <= {BYTE_W{1'b0}};
        end else begin
            csum_q <= csum_d;
        end
    end

    assign o_prog_csum = csum_q;
`else
    assign o_prog_csum = {BYTE_W{1'b0}};
`endif

    assign o_prog_ready  = ready_q;
    assign o_prog_err    = perr_q;
    assign o_fetch_valid = fvalid_q;
    assign o_fetch_data  = fdata_q;
    assign o_fetch_err   = ferr_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
module tb_inst_mem_sync;

    localparam int DEPTH = 128;
    localparam int WB    = 4;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          prog_en = 1'b0;
    logic [7:0]    prog_addr = 8'h00;
    logic          prog_valid = 1'b0;
    logic [7:0]    prog_data = 8'h00;
    logic          prog_ready;
    logic          prog_err;
    logic [7:0]    prog_csum;
    logic          fetch_req = 1'b0;
    logic [7:0]    fetch_addr = 8'h00;
    logic          fetch_valid;
    logic [DW-1:0] fetch_data;
    logic          fetch_err;

    inst_mem_sync dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_prog_en    (prog_en),
        .i_prog_addr  (prog_addr),
        .i_prog_valid (prog_valid),
        .i_prog_data  (prog_data),
        .o_prog_ready (prog_ready),
        .o_prog_err   (prog_err),
        .o_prog_csum  (prog_csum),
        .i_fetch_req  (fetch_req),
        .i_fetch_addr (fetch_addr),
        .o_fetch_valid(fetch_valid),
        .o_fetch_data (fetch_data),
        .o_fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            tag;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem [DEPTH];
    logic [7:0] stream_q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [DW-1:0] last_data = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference word read: plain byte-array lookup with zero beyond DEPTH.
    task automatic push_fetch(input int a, input bit busy);
        exp_t e;
        e.tag = cyc;
        if (busy) begin
            e.err  = 1'b1;
            e.data = '0;
        end else begin
            e.err  = (a + WB - 1 >= DEPTH);
            e.data = '0;
            for (int k = 0; k < WB; k++) begin
                if (a + k < DEPTH) e.data[k*8 +: 8] = ref_mem[a + k];
            end
        end
        fetch_req  = 1'b1;
        fetch_addr = a[7:0];
        exp_q.push_back(e);
    endtask

    task automatic maybe_fetch(input int pct, input bit busy);
        if ($urandom_range(0, 99) < pct) push_fetch($urandom_range(0, 255), busy);
    endtask

    // Monitor: pops one expectation per response and checks latency/content.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            last_data = '0;
        end else begin
            if (fetch_valid) begin
                if (exp_q.size() == 0) begin
                    check("fetch_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("fetch_latency", cyc, e.tag + 1);
                    check("fetch_data", fetch_data, e.data);
                    check("fetch_err", {31'd0, fetch_err}, {31'd0, e.err});
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].tag + 1 <= cyc) begin
                    check("fetch_missing", 32'd0, 32'd1);
                    void'(exp_q.pop_front());
                end
                check("fetch_hold", fetch_data, last_data);
            end
            last_data = fetch_data;
        end
    end

    task automatic idle_cycles(input int n, input int fetch_pct);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            prog_en = 1'b0; prog_valid = 1'b0; fetch_req = 1'b0;
            maybe_fetch(fetch_pct, 1'b0);
        end
    endtask

    // One programming session consuming stream_q; model tracks pointer/full.
    task automatic prog_session(input int start, input int gap_pct, input int fetch_pct);
        int         p;
        bit         full;
        bit         perr;
        logic [7:0] cs;
        logic [7:0] b;
        @(negedge clk);
        fetch_req  = 1'b0;
        prog_en    = 1'b1;
        prog_addr  = start[7:0];
        prog_valid = 1'($urandom_range(0, 1));
        prog_data  = 8'($urandom);
        maybe_fetch(fetch_pct, 1'b0);
        p = start; full = (start >= DEPTH); perr = 1'b0; cs = 8'h00;
        while (stream_q.size() > 0) begin
            @(negedge clk);
            check("prog_ready", {31'd0, prog_ready}, {31'd0, !full});
            fetch_req = 1'b0;
            maybe_fetch(fetch_pct, 1'b1);
            if ($urandom_range(0, 99) < gap_pct) begin
                prog_valid = 1'b0;
                prog_data  = 8'($urandom);
            end else begin
                b = stream_q.pop_front();
                prog_valid = 1'b1;
                prog_data  = b;
                if (!full) begin
                    ref_mem[p] = b;
                    cs = cs ^ b;
                    p++;
                    if (p == DEPTH) full = 1'b1;
                end else begin
                    perr = 1'b1;
                end
            end
        end
        @(negedge clk);
        check("prog_ready_last", {31'd0, prog_ready}, {31'd0, !full});
        prog_en = 1'b0; prog_valid = 1'b0; fetch_req = 1'b0;
        maybe_fetch(fetch_pct, 1'b1);
        @(negedge clk);
        fetch_req = 1'b0;
        check("prog_ready_idle", {31'd0, prog_ready}, 32'd0);
        check("prog_err", {31'd0, prog_err}, {31'd0, perr});
`ifdef INST_MEM_CHECKSUM_EN
        check("prog_csum", {24'd0, prog_csum}, {24'd0, cs});
`else
        check("prog_csum", {24'd0, prog_csum}, 32'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, prog_ready}, 32'd0);
        check("rst_perr", {31'd0, prog_err}, 32'd0);
        check("rst_csum", {24'd0, prog_csum}, 32'd0);
        check("rst_fvalid", {31'd0, fetch_valid}, 32'd0);
        check("rst_fdata", fetch_data, 32'd0);
        check("rst_ferr", {31'd0, fetch_err}, 32'd0);
        rst = 1'b0;

        // Directed: program 11 22 33 44 at 0, aligned then unaligned fetch.
        stream_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        prog_session(8'h00, 0, 0);
        @(negedge clk); fetch_req = 1'b0; push_fetch(8'h00, 1'b0);
        @(negedge clk); fetch_req = 1'b0; push_fetch(8'h01, 1'b0);
        idle_cycles(2, 0);

        // Directed: fill to the end, drop one byte, straddling fetch.
        stream_q = '{8'hAA, 8'hBB, 8'hCC};
        prog_session(8'h7E, 0, 0);
        @(negedge clk); fetch_req = 1'b0; push_fetch(8'h7E, 1'b0);
        idle_cycles(2, 0);

        // Directed: fetches during programming, then back-to-back in IDLE.
        stream_q = '{8'h5A, 8'hA5, 8'h0F};
        prog_session(8'h40, 30, 100);
        @(negedge clk); fetch_req = 1'b0; push_fetch(8'h00, 1'b0);
        @(negedge clk); fetch_req = 1'b0; push_fetch(8'h04, 1'b0);
        @(negedge clk); fetch_req = 1'b0; push_fetch(8'h40, 1'b0);
        idle_cycles(2, 0);

        // Directed: start pointer beyond the array, writes all dropped.
        stream_q = '{8'h77};
        prog_session(8'hC0, 0, 50);
        idle_cycles(2, 50);

        // Randomized sessions with IDLE fetch bursts in between.
        for (int s = 0; s < 24; s++) begin
            int start;
            int len;
            case ($urandom_range(0, 2))
                0:       start = $urandom_range(DEPTH - 8, DEPTH + 2);
                1:       start = $urandom_range(0, 255);
                default: start = $urandom_range(0, DEPTH - 1);
            endcase
            len = $urandom_range(0, 20);
            stream_q.delete();
            for (int i = 0; i < len; i++) stream_q.push_back(8'($urandom));
            prog_session(start, $urandom_range(0, 50), $urandom_range(0, 60));
            idle_cycles($urandom_range(1, 8), $urandom_range(40, 100));
        end

        // Reset in the middle of programming.
        @(negedge clk);
        fetch_req = 1'b0; prog_en = 1'b1; prog_addr = 8'h00; prog_valid = 1'b0;
        @(negedge clk); prog_valid = 1'b1; prog_data = 8'hDE;
        @(negedge clk); prog_valid = 1'b1; prog_data = 8'hAD;
        @(negedge clk); prog_valid = 1'b0;
        check("mid_ready", {31'd0, prog_ready}, 32'd1);
        #1 rst = 1'b1;
        #1 check("rstmid_ready", {31'd0, prog_ready}, 32'd0);
        check("rstmid_fvalid", {31'd0, fetch_valid}, 32'd0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        @(negedge clk);
        prog_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, prog_ready}, 32'd0);
        fetch_req = 1'b0; push_fetch(8'h00, 1'b0);
        idle_cycles(4, 0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
